// File: rtl/mfu_pkg.sv
// ---------------------------------------------------------------------------
// mfu_pkg
//
// Definitions shared by the multi-precision fusion unit (MFU) blocks:
//   - state_t   : sequencer FSM states (IDLE, RUN, DONE)
//   - DIGIT_W   : width of one mBB operand digit (2 bits)
//   - PP_W      : width of one mBB partial product (4 bits)
//   - SEL_A/B   : bit positions inside the mBB sel vector that mark the
//                 a / b digit as a two's-complement (signed) digit
//   - pp_fill() : fill bit used to widen an mBB partial product
// ---------------------------------------------------------------------------
package mfu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DIGIT_W = 2;
    localparam int PP_W    = 2 * DIGIT_W;
    localparam int SEL_A   = 1;
    localparam int SEL_B   = 0;

    // A partial product is signed exactly when at least one of its digits
    // is signed. A signed partial product is widened with its top bit, and
    // an unsigned one is widened with zeros.
    function automatic logic pp_fill(input logic [PP_W-1:0] pp,
                                     input logic [1:0]      sel);
        return (sel != 2'b00) && pp[PP_W-1];
    endfunction

endpackage

// File: rtl/mbb_seq_mul_mbb.sv
// ---------------------------------------------------------------------------
// mfu_mbb
//
// The 2-bit x 2-bit mBB building block of the MFU. It is purely
// combinational. Each digit is read as unsigned or as two's complement,
// depending on its sel bit. The 4-bit result is the exact product: every
// signed/unsigned digit combination fits in 4 bits. The result is
// two's complement whenever sel != 0.
//
// Ports:
//   en  in  1  enable. When low, p is forced to 0.
//   a   in  2  a digit
//   b   in  2  b digit
//   sel in  2  sel[SEL_A] = a digit signed, sel[SEL_B] = b digit signed
//   p   out 4  digit product
// ---------------------------------------------------------------------------
module mfu_mbb
    import mfu_pkg::*;
(
    input  logic               en,
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic [1:0]         sel,
    output logic [PP_W-1:0]    p
);

    logic [PP_W-1:0] aExt;
    logic [PP_W-1:0] bExt;
    logic [PP_W-1:0] prod;

    // The product is exact modulo 16 once both digits are widened to 4 bits
    // with the correct signedness.
    assign aExt = {{(PP_W-DIGIT_W){sel[SEL_A] & a[DIGIT_W-1]}}, a};
    assign bExt = {{(PP_W-DIGIT_W){sel[SEL_B] & b[DIGIT_W-1]}}, b};
    assign prod = aExt * bExt;
    assign p    = en ? prod : '0;

endmodule

// File: rtl/mbb_seq_mul.sv
// ---------------------------------------------------------------------------
// mbb_seq_mul
//
// Minimal-area WIDTH x WIDTH multiplier for the MFU. A single mBB block is
// time-multiplexed over all D*D digit pairs (D = WIDTH/2). Each shifted
// partial product is added into a 2*WIDTH-bit accumulator.
//
// Ports:
//   clk        in  1        clock, rising edge
//   nrst       in  1        synchronous active-low reset
//   in_valid   in  1        operand pair valid
//   in_ready   out 1        ready for operands (IDLE only)
//   a, b       in  WIDTH    multiplicand / multiplier
//   a_signed   in  1        a is two's complement
//   b_signed   in  1        b is two's complement
//   out_valid  out 1        result valid (DONE)
//   out_ready  in  1        consumer accepts result
//   p          out 2*WIDTH  product
//   busy       out 1        RUN or DONE
//
// Optional feature: define MBB_SEQ_ZSKIP_EN to enable zero-row skipping.
// With it, a row whose a digit is zero costs one idle cycle instead of D
// cycles. The result is identical.
// ---------------------------------------------------------------------------
module mbb_seq_mul
    import mfu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               a_signed,
    input  logic               b_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p,
    output logic               busy
);

    localparam int D     = WIDTH / DIGIT_W;
    localparam int CNT_W = (D > 1) ? $clog2(D) : 1;
    localparam int ACC_W = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(D - 1);

    state_t             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               aSigned_q;
    logic               bSigned_q;
    logic [CNT_W-1:0]   i_q;
    logic [CNT_W-1:0]   j_q;
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   acc_d;
    logic               inReady_q;
    logic               outValid_q;
    logic               busy_q;

    logic               mbbEn;
    logic [DIGIT_W-1:0] digA;
    logic [DIGIT_W-1:0] digB;
    logic [1:0]         mbbSel;
    logic [PP_W-1:0]    mbbP;
    logic               rowDone;
    logic [CNT_W:0]     digitSum;
    logic [CNT_W+1:0]   shamt;
    logic [ACC_W-1:0]   ppExt;

    mfu_mbb u_mbb (
        .en  (mbbEn),
        .a   (digA),
        .b   (digB),
        .sel (mbbSel),
        .p   (mbbP)
    );

    // The mBB is only driven in RUN. In any other state all of its inputs are
    // zero. Only the top digit of a signed operand is itself signed.
    always_comb begin
        mbbEn   = 1'b0;
        digA    = '0;
        digB    = '0;
        mbbSel  = '0;
        rowDone = 1'b0;
        if (state_q == RUN) begin
            mbbEn         = 1'b1;
            digA          = a_q[{i_q, 1'b0} +: DIGIT_W];
            digB          = b_q[{j_q, 1'b0} +: DIGIT_W];
            mbbSel[SEL_A] = aSigned_q && (i_q == LAST);
            mbbSel[SEL_B] = bSigned_q && (j_q == LAST);
            rowDone       = (j_q == LAST);
`ifdef MBB_SEQ_ZSKIP_EN
            // A zero a digit contributes nothing to its whole row, so the row
            // is closed on its first cycle with the mBB disabled.
            if ((j_q == '0) && (digA == '0)) begin
                mbbEn   = 1'b0;
                rowDone = 1'b1;
            end
`endif
        end
    end

    // The weight of digit pair (i, j) is 4^(i+j), which is a left shift by
    // 2*(i+j). A disabled mBB yields p = 0, so a skipped row adds nothing.
    always_comb begin
        digitSum = {1'b0, i_q} + {1'b0, j_q};
        shamt    = {digitSum, 1'b0};
        ppExt    = {{(ACC_W-PP_W){pp_fill(mbbP, mbbSel)}}, mbbP};
        acc_d    = acc_q + (ppExt << shamt);
    end

    // Sequencer FSM. The handshake and status outputs are registered
    // alongside the state, so no input reaches them combinationally.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            aSigned_q  <= 1'b0;
            bSigned_q  <= 1'b0;
            i_q        <= '0;
            j_q        <= '0;
            acc_q      <= '0;
            inReady_q  <= 1'b1;
            outValid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q       <= a;
                        b_q       <= b;
                        aSigned_q <= a_signed;
                        bSigned_q <= b_signed;
                        i_q       <= '0;
                        j_q       <= '0;
                        acc_q     <= '0;
                        inReady_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= RUN;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    if (rowDone) begin
                        j_q <= '0;
                        if (i_q == LAST) begin
                            outValid_q <= 1'b1;
                            state_q    <= DONE;
                        end else begin
                            i_q <= i_q + 1'b1;
                        end
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        outValid_q <= 1'b0;
                        busy_q     <= 1'b0;
                        inReady_q  <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    inReady_q  <= 1'b1;
                    outValid_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = inReady_q;
    assign out_valid = outValid_q;
    assign busy      = busy_q;
    assign p         = acc_q;

endmodule

// File: tb/tb_mbb_seq_mul.sv
// ---------------------------------------------------------------------------
// tb_mbb_seq_mul
//
// Self-checking bench for mbb_seq_mul with WIDTH=8. Products come from
// plain integer multiplication of the operands. Latency comes from the
// digit count. Both follow MBB_SEQ_ZSKIP_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_mbb_seq_mul;

    localparam int W = 8;
    localparam int D = W / 2;

    logic           clk = 1'b0;
    logic           nrst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           a_signed;
    logic           b_signed;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] p;
    logic           busy;

    int total = 0;
    int bad   = 0;
    int cycleCnt = 0;

    mbb_seq_mul #(.WIDTH(W)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .a_signed  (a_signed),
        .b_signed  (b_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Reference product. Each operand is taken as a signed or unsigned
    // integer, the two are multiplied, and the result is truncated to 2*W
    // bits.
    function automatic logic [2*W-1:0] refProduct(input logic [W-1:0] aa,
                                                  input logic [W-1:0] bb,
                                                  input logic as,
                                                  input logic bs);
        longint sa;
        longint sb;
        longint pr;
        sa = as ? longint'($signed(aa)) : longint'(aa);
        sb = bs ? longint'($signed(bb)) : longint'(bb);
        pr = sa * sb;
        return pr[2*W-1:0];
    endfunction

    // Number of RUN cycles for multiplicand aa.
    function automatic int refRun(input logic [W-1:0] aa);
        int n;
        n = 0;
`ifdef MBB_SEQ_ZSKIP_EN
        for (int k = 0; k < D; k++)
            n += (((aa >> (2 * k)) & 8'h03) != 0) ? D : 1;
`else
        n = D * D + 0 * int'(aa[0]);
`endif
        return n;
    endfunction

    // Issues one operand pair and waits for out_valid. It leaves the result
    // pending. lat is the spec's cycle offset: the cycle after accept = 1.
    task automatic issue(input logic [W-1:0] aa, input logic [W-1:0] bb,
                         input logic as, input logic bs,
                         output int lat, output logic [2*W-1:0] res,
                         output int acceptCycle, output bit tmo);
        int guard;
        guard = 0;
        tmo   = 1'b0;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        a = aa; b = bb; a_signed = as; b_signed = bs; in_valid = 1'b1;
        @(posedge clk); #1;
        acceptCycle = cycleCnt;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom);
        a_signed = 1'($urandom); b_signed = 1'($urandom);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        tmo = !out_valid || (guard >= 200);
        res = p;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        total++; if (p !== 16'h0000) begin bad++; $display("[TB] FAIL reset_p got=%h exp=0000", p); end
        nrst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [W-1:0]   ta [6] = '{8'hFF, 8'h80, 8'h7F, 8'hFF, 8'hFF, 8'h03};
        logic [W-1:0]   tb [6] = '{8'hFF, 8'h80, 8'h80, 8'hFF, 8'hFF, 8'h05};
        logic           tas[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic           tbs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [2*W-1:0] tp [6] = '{16'hFE01, 16'h4000, 16'hC080, 16'hFF01, 16'hFF01, 16'h000F};
        int lat, acc;
        logic [2*W-1:0] res;
        bit tmo;
        for (int k = 0; k < 6; k++) begin
            issue(ta[k], tb[k], tas[k], tbs[k], lat, res, acc, tmo);
            total++; if (tmo) begin bad++; $display("[TB] FAIL directed_timeout vec=%0d", k); end
            total++; if (res !== tp[k]) begin bad++; $display("[TB] FAIL directed_p vec=%0d got=%h exp=%h", k, res, tp[k]); end
            total++; if (lat != refRun(ta[k]) + 1) begin bad++; $display("[TB] FAIL directed_latency vec=%0d got=%0d exp=%0d", k, lat, refRun(ta[k]) + 1); end
            consume();
            total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("[TB] FAIL directed_release vec=%0d in_ready=%b out_valid=%b exp 1/0", k, in_ready, out_valid); end
        end
    endtask

    task automatic test_zskip_latency();
        int lat, acc, expLat;
        logic [2*W-1:0] res;
        bit tmo;
`ifdef MBB_SEQ_ZSKIP_EN
        expLat = 8;
`else
        expLat = 17;
`endif
        issue(8'h01, 8'h03, 1'b0, 1'b0, lat, res, acc, tmo);
        total++; if (res !== 16'h0003) begin bad++; $display("[TB] FAIL zskip_p got=%h exp=0003", res); end
        total++; if (lat != expLat) begin bad++; $display("[TB] FAIL zskip_latency got=%0d exp=%0d", lat, expLat); end
        consume();
    endtask

    task automatic test_backpressure();
        int lat, acc;
        logic [2*W-1:0] res;
        logic [2*W-1:0] expP;
        bit tmo;
        expP = refProduct(8'h5A, 8'hC3, 1'b1, 1'b0);
        issue(8'h5A, 8'hC3, 1'b1, 1'b0, lat, res, acc, tmo);
        total++; if (tmo || res !== expP) begin bad++; $display("[TB] FAIL bp_p got=%h exp=%h tmo=%0d", res, expP, tmo); end
        for (int k = 0; k < 5; k++) begin
            in_valid = k[0];
            a = W'($urandom); b = W'($urandom);
            @(posedge clk); #1;
            total++; if (p !== expP || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                bad++; $display("[TB] FAIL bp_hold cyc=%0d p=%h exp=%h out_valid=%b in_ready=%b", k, p, expP, out_valid, in_ready);
            end
        end
        in_valid = 1'b0;
        consume();
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("[TB] FAIL bp_release out_valid=%b in_ready=%b busy=%b exp 0/1/0", out_valid, in_ready, busy);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat, acc;
        logic [2*W-1:0] res;
        bit tmo;
        a = 8'hB7; b = 8'h6D; a_signed = 1'b1; b_signed = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) begin @(posedge clk); #1; end
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL midrun_busy got=%b exp=1", busy); end
        nrst = 1'b0;
        @(posedge clk); #1;
        total++; if (busy !== 1'b0 || out_valid !== 1'b0 || p !== 16'h0 || in_ready !== 1'b1) begin
            bad++; $display("[TB] FAIL midrun_reset busy=%b out_valid=%b p=%h in_ready=%b exp 0/0/0000/1", busy, out_valid, p, in_ready);
        end
        nrst = 1'b1;
        issue(8'd3, 8'd5, 1'b0, 1'b0, lat, res, acc, tmo);
        total++; if (tmo || res !== 16'd15) begin bad++; $display("[TB] FAIL midrun_after got=%h exp=000f tmo=%0d", res, tmo); end
        consume();
    endtask

    task automatic test_back_to_back();
        int lat, acc1, acc2;
        logic [2*W-1:0] res;
        bit tmo;
        issue(8'hC4, 8'h39, 1'b0, 1'b1, lat, res, acc1, tmo);
        total++; if (res !== refProduct(8'hC4, 8'h39, 1'b0, 1'b1)) begin bad++; $display("[TB] FAIL b2b_first got=%h exp=%h", res, refProduct(8'hC4, 8'h39, 1'b0, 1'b1)); end
        consume();
        issue(8'h2E, 8'hF1, 1'b1, 1'b1, lat, res, acc2, tmo);
        total++; if (acc2 - acc1 != refRun(8'hC4) + 2) begin bad++; $display("[TB] FAIL b2b_interval got=%0d exp=%0d", acc2 - acc1, refRun(8'hC4) + 2); end
        total++; if (res !== refProduct(8'h2E, 8'hF1, 1'b1, 1'b1)) begin bad++; $display("[TB] FAIL b2b_second got=%h exp=%h", res, refProduct(8'h2E, 8'hF1, 1'b1, 1'b1)); end
        consume();
    endtask

    task automatic test_random();
        int lat, acc;
        logic [2*W-1:0] res;
        logic [2*W-1:0] expP;
        logic [W-1:0] ra, rb;
        logic rs, ts;
        bit tmo;
        for (int k = 0; k < 40; k++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if (k % 5 == 0) ra[3:2] = 2'b00;
            rs = 1'($urandom); ts = 1'($urandom);
            expP = refProduct(ra, rb, rs, ts);
            issue(ra, rb, rs, ts, lat, res, acc, tmo);
            total++; if (tmo || res !== expP) begin bad++; $display("[TB] FAIL rand_p k=%0d a=%h b=%h s=%b%b got=%h exp=%h", k, ra, rb, rs, ts, res, expP); end
            total++; if (lat != refRun(ra) + 1) begin bad++; $display("[TB] FAIL rand_latency k=%0d got=%0d exp=%0d", k, lat, refRun(ra) + 1); end
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            consume();
        end
    endtask

    initial begin
        nrst = 1'b0; in_valid = 1'b0; a = '0; b = '0;
        a_signed = 1'b0; b_signed = 1'b0; out_ready = 1'b0;
        test_reset();
        test_directed();
        test_zskip_latency();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mbb_seq_mul.md
# mbb_seq_mul

Sequencer that computes a WIDTH×WIDTH integer product by time-multiplexing a single 2-bit mBB building block of the multi-precision fusion unit (MFU). It accepts one operand pair through a valid/ready handshake, walks all 2-bit digit pairs through mBB, and accumulates the shifted partial products. It presents the 2·WIDTH-bit result through a second valid/ready handshake. It is the minimal-area multiply path in the MFU and the sequencing reference for the wider fused arrays.

## Interface
- WIDTH, 8: operand width. Must be even and ≥ 4. D = WIDTH/2 digits per operand.
- clk  in  1  clock; all state changes on the rising edge.
- nrst  in  1  reset, synchronous, active-low.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept; high only in IDLE.
- a, b  in  WIDTH  multiplicand and multiplier.
- a_signed, b_signed  in  1  treat a / b as two's complement.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- p  out  2·WIDTH  product, signed when either operand is signed.
- busy  out  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch a, b, a_signed and b_signed. Clear the accumulator, set i=j=0, and go to RUN.
- RUN drives the internal mBB each cycle:
  - en=1.
  - a digit = a[2i+1:2i] and b digit = b[2j+1:2j].
  - sel[1] = a_signed && (i==D-1).
  - sel[0] = b_signed && (j==D-1).
- Accumulate: acc += ext(mBB.p) << 2·(i+j).
  - ext sign-extends mBB.p when sel≠0 and zero-extends it when sel=0.
  - acc is 2·WIDTH bits; wrap modulo 2^(2·WIDTH) is correct by construction.
- Iteration order: j inner (0..D-1), i outer (0..D-1). After i=j=D-1, go to DONE.
- DONE: out_valid=1 and p=acc, held stable until out_ready. On out_valid&&out_ready, go to IDLE.
- The mBB enable is 0 in IDLE and DONE, and its digit and sel inputs are driven 0.
- Inputs in_valid, a and b are ignored outside IDLE. There is no overlap: a new operand pair is never accepted while a result is pending.
- out_ready asserted outside DONE has no effect.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, p=0, busy=0, acc=0, i=j=0, mBB en=0.
- nrst low in any state (including mid-RUN or DONE with output pending) forces the reset values on the next edge. The in-flight operation is discarded.
- Accept at edge T. RUN occupies cycles T+1 .. T+D². out_valid rises at T+D²+1, which is 17 cycles for WIDTH=8.
- DONE→IDLE on the handshake edge. in_ready is high the following cycle, so the minimum issue interval is D²+2 cycles.
- in_ready, busy and out_valid are decoded from registered state only. There is no combinational in→out path.

## Configuration
- MBB_SEQ_ZSKIP_EN: zero-row skipping.
  - Defined: on entering a row with i such that a digit i == 0, that row takes one cycle with mBB en=0 and no accumulation, then i advances and j resets. RUN length is D·(nonzero a digits) + (zero a digits), minimum D cycles. The result is identical to the non-skip build.
  - Undefined: fixed D² RUN cycles, with no data-dependent latency.

## Structure
- Shared package mfu_pkg:
  - state enum.
  - DIGIT_W=2.
  - sel bit positions SEL_A=1 and SEL_B=0.
  - helper function for the partial-product extension.
- Sub-modules: instantiate the existing mBB only; no new sub-module. Counters, FSM and accumulator stay in this module.

## Test plan
- Unsigned 0xFF×0xFF, out_ready=1: p=0xFE01, with out_valid exactly 17 cycles after accept and in_ready back high the cycle after the handshake.
- Signed −128×−128 (a=b=0x80, both signed): p=0x4000. Signed 0x7F×0x80: p=0xC080 (−16256).
- Mixed: a=0xFF signed (−1), b=0xFF unsigned (255): p=0xFF01 (−255). Also check the swapped signedness.
- Backpressure: hold out_ready=0 for 5 cycles in DONE. p stays stable, in_ready=0, and in_valid pulses are ignored. The result is consumed on the first out_ready=1 edge.
- Reset mid-RUN at the 8th RUN cycle: next cycle shows state IDLE, out_valid=0, p=0 and in_ready=1. A new 3×5 unsigned operation then yields p=15.
- With MBB_SEQ_ZSKIP_EN: a=0x01, b=0x03 unsigned gives p=0x0003 with out_valid at T+8 (4+1+1+1 RUN cycles). Without the macro, the same operands give out_valid at T+17.
